// File: rtl/engine_forward_lane_router.sv
// rtl/engine_forward_lane_router.sv - forwarded-data router into per-lane FWFT queues
// Optional statistics counters: define ENGINE_FORWARD_LANE_ROUTER_STATS_EN.
// Packets pass through a single pending register, then fan out to the lane FIFOs
// selected by the decoded mask. in_ready is registered and conservatively
// throttled by a per-lane almost-full threshold, so a lane FIFO never overflows.
module engine_forward_lane_router #(
  parameter int NUM_LANES     = 4,
  parameter int LANE_ID_WIDTH = 3,
  parameter int DATA_WIDTH    = 64,
  parameter int FIFO_DEPTH    = 16,
  parameter int PROG_THRESH   = 12,
  parameter int IDLE_CYCLES   = 8
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANE_ID_WIDTH-1:0]        in_lane,
  input  logic                            in_broadcast,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic [NUM_LANES-1:0]            out_valid,
  input  logic [NUM_LANES-1:0]            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic                            fifo_setup_signal,
  output logic                            done_out,
  output logic [NUM_LANES*32-1:0]         stat_lane_count,
  output logic [31:0]                     stat_drop_count,
  output logic [31:0]                     stat_stall_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int DONE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [OCC_W:0]    THRESH_V = (OCC_W+1)'(PROG_THRESH);
  localparam logic [DONE_W-1:0] IDLE_V   = DONE_W'(IDLE_CYCLES);

  logic                  setup_q, setup_d;
  logic                  in_ready_q, in_ready_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_LANES-1:0]  pend_mask_q, pend_mask_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [DONE_W-1:0]     done_cnt_q, done_cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [NUM_LANES][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [NUM_LANES][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [NUM_LANES];
  logic [PTR_W-1:0]      wr_ptr_d [NUM_LANES];
  logic [PTR_W-1:0]      rd_ptr_q [NUM_LANES];
  logic [PTR_W-1:0]      rd_ptr_d [NUM_LANES];
  logic [OCC_W-1:0]      occ_q [NUM_LANES];
  logic [OCC_W-1:0]      occ_d [NUM_LANES];
  logic [OCC_W:0]        lane_sum [NUM_LANES];

  logic                  accept;
  logic [NUM_LANES-1:0]  mask_dec;
  logic [NUM_LANES-1:0]  lane_nonempty;
  logic [NUM_LANES-1:0]  push;
  logic [NUM_LANES-1:0]  pop;

  // Input accept and lane mask decode; an out-of-range lane decodes to an empty mask (drop).
  always_comb begin
    accept   = in_valid & in_ready_q;
    mask_dec = '0;
    if (in_broadcast) begin
      mask_dec = '1;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (in_lane == LANE_ID_WIDTH'(l)) mask_dec[l] = 1'b1;
      end
    end
  end

  // Pending register captures every accepted packet, including drops.
  always_comb begin
    setup_d      = 1'b0;
    pend_valid_d = accept;
    pend_mask_d  = accept ? mask_dec : '0;
    pend_data_d  = accept ? in_data : pend_data_q;
  end

  // Lane FIFO bookkeeping: push from the pending register, pop on head handshake.
  always_comb begin
    mem_d = mem_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_nonempty[l] = (occ_q[l] != '0);
      push[l]          = pend_valid_q & pend_mask_q[l];
      pop[l]           = lane_nonempty[l] & out_ready[l];
      wr_ptr_d[l]      = wr_ptr_q[l];
      rd_ptr_d[l]      = rd_ptr_q[l];
      occ_d[l]         = occ_q[l];
      if (push[l]) begin
        mem_d[l][wr_ptr_q[l]] = pend_data_q;
        wr_ptr_d[l]           = wr_ptr_q[l] + 1'b1;
      end
      if (pop[l]) rd_ptr_d[l] = rd_ptr_q[l] + 1'b1;
      case ({push[l], pop[l]})
        2'b10:   occ_d[l] = occ_q[l] + 1'b1;
        2'b01:   occ_d[l] = occ_q[l] - 1'b1;
        default: occ_d[l] = occ_q[l];
      endcase
    end
  end

  // Next in_ready: worst case occupancy ignores pops so a stall cannot overshoot the threshold by more than one.
  always_comb begin
    in_ready_d = ~setup_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_sum[l] = {1'b0, occ_q[l]}
                  + {{OCC_W{1'b0}}, pend_valid_q & pend_mask_q[l]}
                  + {{OCC_W{1'b0}}, accept & mask_dec[l]};
      if (!(lane_sum[l] < THRESH_V)) in_ready_d = 1'b0;
    end
  end

  // Idle counter: any activity or queued data restarts it; otherwise count up and saturate.
  always_comb begin
    done_cnt_d = done_cnt_q;
    if (accept | pend_valid_q | (|lane_nonempty)) begin
      done_cnt_d = '0;
    end else if (done_cnt_q != IDLE_V) begin
      done_cnt_d = done_cnt_q + 1'b1;
    end
  end

  // Control and pointer state; reset discards queued and pending data.
  always_ff @(posedge ap_clk) begin
    pend_data_q <= pend_data_d;
    if (areset) begin
      setup_q      <= 1'b1;
      in_ready_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_mask_q  <= '0;
      done_cnt_q   <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        occ_q[l]    <= '0;
      end
    end else begin
      setup_q      <= setup_d;
      in_ready_q   <= in_ready_d;
      pend_valid_q <= pend_valid_d;
      pend_mask_q  <= pend_mask_d;
      done_cnt_q   <= done_cnt_d;
      for (int l = 0; l < NUM_LANES; l++) begin
        wr_ptr_q[l] <= wr_ptr_d[l];
        rd_ptr_q[l] <= rd_ptr_d[l];
        occ_q[l]    <= occ_d[l];
      end
    end
  end

  // Lane storage has no reset; contents are only observable while occupancy is nonzero.
  always_ff @(posedge ap_clk) begin
    mem_q <= mem_d;
  end

  // FWFT outputs: head of each lane.
  always_comb begin
    out_data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      out_data[l*DATA_WIDTH +: DATA_WIDTH] = mem_q[l][rd_ptr_q[l]];
    end
  end

  assign out_valid         = lane_nonempty;
  assign in_ready          = in_ready_q;
  assign fifo_setup_signal = setup_q;
  assign done_out          = (done_cnt_q == IDLE_V);

`ifdef ENGINE_FORWARD_LANE_ROUTER_STATS_EN
  logic [31:0] stat_lane_q [NUM_LANES];
  logic [31:0] stat_lane_d [NUM_LANES];
  logic [31:0] stat_drop_q, stat_drop_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Statistics next-state: lane pushes, dropped accepts, post-setup stalls; all wrap.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      stat_lane_d[l] = stat_lane_q[l] + {31'b0, push[l]};
    end
    stat_drop_d  = stat_drop_q + {31'b0, accept & ~(|mask_dec)};
    stat_stall_d = stat_stall_q + {31'b0, in_valid & ~in_ready_q & ~setup_q};
  end

  // Statistics registers.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      for (int l = 0; l < NUM_LANES; l++) stat_lane_q[l] <= '0;
      stat_drop_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) stat_lane_q[l] <= stat_lane_d[l];
      stat_drop_q  <= stat_drop_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  // Pack per-lane counters onto the flat port.
  always_comb begin
    stat_lane_count = '0;
    for (int l = 0; l < NUM_LANES; l++) stat_lane_count[l*32 +: 32] = stat_lane_q[l];
  end

  assign stat_drop_count  = stat_drop_q;
  assign stat_stall_count = stat_stall_q;
`else
  assign stat_lane_count  = '0;
  assign stat_drop_count  = '0;
  assign stat_stall_count = '0;
`endif

endmodule
